// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM soft-start / duty-ramp sequencer:
//   - ramp_state_e : sequencer state encoding (IDLE, INIT, RAMP, RUN)
//   - step_toward  : one saturating duty step toward a target value
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RAMP = 2'd2,
        RUN  = 2'd3
    } ramp_state_e;

    // Moves cur toward tgt by stp and clamps at tgt, so the result never
    // overshoots in either direction. The distance to the target is compared
    // against the step before adding or subtracting, which means no
    // intermediate value can wrap. Operands are zero-extended duty words.
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] stp);
        logic [31:0] res;
        res = cur;
        if (cur < tgt) begin
            if ((tgt - cur) <= stp) res = tgt;
            else                    res = cur + stp;
        end else if (cur > tgt) begin
            if ((cur - tgt) <= stp) res = tgt;
            else                    res = cur - stp;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_hold_timer.sv
// -----------------------------------------------------------------------------
// pwm_hold_timer
// Periods-per-step counter for the ramp sequencer. Counts PWM period events
// and emits a one-cycle tick on the event that finds the count equal to
// hold_cyc, then restarts from zero. hold_cyc = 0 ticks on every event.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   pe        : PWM period event (already gated by pause)
//   clr       : synchronous clear of the count, overrides pe
//   hold_cyc  : extra periods between steps
//   tick      : combinational step strobe, valid in the pe cycle
// -----------------------------------------------------------------------------
module pwm_hold_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int B_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pe,
    input  logic              clr,
    input  logic [B_HOLD-1:0] hold_cyc,
    output logic              tick
);

    logic [B_HOLD-1:0] cnt_q;
    logic [B_HOLD-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (pe) begin
            if (cnt_q == hold_cyc) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + B_HOLD'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Soft-start / duty-ramp sequencer in front of one pwm instance. A start
// request resets the pwm counters (INIT), then steps the duty word toward the
// target every (hold_cyc+1) pwm periods (RAMP), then holds it (RUN) until a
// retarget or abort. All outputs are registered.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, abort        : single-cycle requests (abort has priority)
//   pause               : level freeze of the pwm and the ramp
//   target_width, step, hold_cyc, cfg_clk : configuration latched on start
//   pwm_cyc, pwm_clk_en : status from the pwm
//   sel_width, sel_clk, count_en, s_rst   : controls to the pwm
//   busy, at_target, done                 : sequencer status
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int B_WIDTH = 8,
    parameter int B_CLK   = 3,
    parameter int B_HOLD  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [B_WIDTH-1:0] target_width,
    input  logic [B_WIDTH-1:0] step,
    input  logic [B_HOLD-1:0]  hold_cyc,
    input  logic [B_CLK-1:0]   cfg_clk,
    input  logic               pwm_cyc,
    input  logic               pwm_clk_en,
    output logic [B_WIDTH-1:0] sel_width,
    output logic [B_CLK-1:0]   sel_clk,
    output logic               count_en,
    output logic               s_rst,
    output logic               busy,
    output logic               at_target,
    output logic               done
);

    ramp_state_e        state_q, state_d;
    logic [B_WIDTH-1:0] sel_width_q, sel_width_d;
    logic [B_CLK-1:0]   sel_clk_q, sel_clk_d;
    logic               count_en_q, count_en_d;
    logic               s_rst_q, s_rst_d;
    logic               busy_q, busy_d;
    logic               at_target_q, at_target_d;
    logic               done_q, done_d;
    logic [B_WIDTH-1:0] target_q, target_d;
    logic [B_WIDTH-1:0] step_q, step_d;
    logic [B_HOLD-1:0]  hold_cyc_q, hold_cyc_d;

    logic               pe;
    logic               hold_clr;
    logic               hold_tick;
    logic [B_WIDTH-1:0] step_eff;

    assign pe       = pwm_cyc & pwm_clk_en & ~pause;
    // Counter only runs in RAMP; any start (retarget) restarts the step period.
    assign hold_clr = (state_q != RAMP) | start | abort;
    // A zero step would stall the ramp forever, so it is promoted to 1.
    assign step_eff = (step == '0) ? B_WIDTH'(1) : step;

    pwm_hold_timer #(
        .B_HOLD (B_HOLD)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .pe       (pe),
        .clr      (hold_clr),
        .hold_cyc (hold_cyc_q),
        .tick     (hold_tick)
    );

    always_comb begin
        state_d     = state_q;
        sel_width_d = sel_width_q;
        sel_clk_d   = sel_clk_q;
        count_en_d  = ~pause;
        s_rst_d     = s_rst_q;
        busy_d      = busy_q;
        at_target_d = at_target_q;
        done_d      = 1'b0;
        target_d    = target_q;
        step_d      = step_q;
        hold_cyc_d  = hold_cyc_q;

        if (abort) begin
            state_d     = IDLE;
            sel_width_d = '0;
            s_rst_d     = 1'b1;
            busy_d      = 1'b0;
            at_target_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_rst_d     = 1'b1;
                    sel_width_d = '0;
                    busy_d      = 1'b0;
                    at_target_d = 1'b0;
                    if (start) begin
                        target_d   = target_width;
                        step_d     = step_eff;
                        hold_cyc_d = hold_cyc;
                        sel_clk_d  = cfg_clk;
                        state_d    = INIT;
                        busy_d     = 1'b1;
                    end
                end
                INIT: begin
                    s_rst_d = 1'b1;
                    busy_d  = 1'b1;
                    if (start) begin
                        target_d   = target_width;
                        step_d     = step_eff;
                        hold_cyc_d = hold_cyc;
                    end
                    // Leave reset aligned to a pwm clock enable so the pwm
                    // starts its first period cleanly.
                    if (pwm_clk_en && !pause) begin
                        state_d = RAMP;
                        s_rst_d = 1'b0;
                    end
                end
                RAMP: begin
                    s_rst_d = 1'b0;
                    busy_d  = 1'b1;
                    if (start) begin
                        // Retarget: the arrival check resumes next cycle
                        // against the new target from the current duty.
                        target_d   = target_width;
                        step_d     = step_eff;
                        hold_cyc_d = hold_cyc;
                    end else if (!pause && (sel_width_q == target_q)) begin
                        done_d      = 1'b1;
                        state_d     = RUN;
                        busy_d      = 1'b0;
                        at_target_d = 1'b1;
                    end else if (hold_tick) begin
                        sel_width_d = B_WIDTH'(step_toward(32'(sel_width_q),
                                                           32'(target_q),
                                                           32'(step_q)));
                    end
                end
                RUN: begin
                    s_rst_d     = 1'b0;
                    busy_d      = 1'b0;
                    at_target_d = 1'b1;
                    if (start) begin
                        target_d    = target_width;
                        step_d      = step_eff;
                        hold_cyc_d  = hold_cyc;
                        state_d     = RAMP;
                        busy_d      = 1'b1;
                        at_target_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    sel_width_d = '0;
                    s_rst_d     = 1'b1;
                    busy_d      = 1'b0;
                    at_target_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_width_q <= '0;
            sel_clk_q   <= '0;
            count_en_q  <= 1'b1;
            s_rst_q     <= 1'b1;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
            done_q      <= 1'b0;
            target_q    <= '0;
            step_q      <= '0;
            hold_cyc_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_width_q <= sel_width_d;
            sel_clk_q   <= sel_clk_d;
            count_en_q  <= count_en_d;
            s_rst_q     <= s_rst_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
            done_q      <= done_d;
            target_q    <= target_d;
            step_q      <= step_d;
            hold_cyc_q  <= hold_cyc_d;
        end
    end

    assign sel_width = sel_width_q;
    assign sel_clk   = sel_clk_q;
    assign count_en  = count_en_q;
    assign s_rst     = s_rst_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
// Directed bench for pwm_ramp_ctrl. The pwm status inputs (pwm_cyc,
// pwm_clk_en) are driven directly so every period event is placed by hand.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int BW = 8;
    localparam int BC = 3;
    localparam int BH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, pause;
    logic [BW-1:0] target_width, step;
    logic [BH-1:0] hold_cyc;
    logic [BC-1:0] cfg_clk;
    logic          pwm_cyc, pwm_clk_en;
    logic [BW-1:0] sel_width;
    logic [BC-1:0] sel_clk;
    logic          count_en, s_rst, busy, at_target, done;

    int errors = 0;
    int checks = 0;

    pwm_ramp_ctrl #(
        .B_WIDTH (BW),
        .B_CLK   (BC),
        .B_HOLD  (BH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .target_width (target_width),
        .step         (step),
        .hold_cyc     (hold_cyc),
        .cfg_clk      (cfg_clk),
        .pwm_cyc      (pwm_cyc),
        .pwm_clk_en   (pwm_clk_en),
        .sel_width    (sel_width),
        .sel_clk      (sel_clk),
        .count_en     (count_en),
        .s_rst        (s_rst),
        .busy         (busy),
        .at_target    (at_target),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_once();
        pwm_cyc    = 1'b1;
        pwm_clk_en = 1'b1;
        cyc();
        pwm_cyc    = 1'b0;
        pwm_clk_en = 1'b0;
    endtask

    task automatic wake_init();
        pwm_clk_en = 1'b1;
        cyc();
        pwm_clk_en = 1'b0;
    endtask

    task automatic start_req(input logic [BW-1:0] t, input logic [BW-1:0] s,
                             input logic [BH-1:0] h, input logic [BC-1:0] c);
        target_width = t;
        step         = s;
        hold_cyc     = h;
        cfg_clk      = c;
        start        = 1'b1;
        cyc();
        start        = 1'b0;
    endtask

    task automatic abort_req();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        target_width = '0; step = '0; hold_cyc = '0; cfg_clk = '0;
        pwm_cyc = 1'b0; pwm_clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then idle with no stimulus
        chk("rst_sel_width", sel_width, 0);
        chk("rst_s_rst", s_rst, 1);
        chk("rst_count_en", count_en, 1);
        chk("rst_busy", busy, 0);
        chk("rst_at_target", at_target, 0);
        chk("rst_done", done, 0);
        chk("rst_sel_clk", sel_clk, 0);
        repeat (10) cyc();
        chk("idle_sel_width", sel_width, 0);
        chk("idle_s_rst", s_rst, 1);
        chk("idle_busy", busy, 0);

        // Ramp up 0 -> 0x40 by 0x10 every period
        start_req(8'h40, 8'h10, 4'd0, 3'd2);
        chk("s1_init_busy", busy, 1);
        chk("s1_init_s_rst", s_rst, 1);
        chk("s1_sel_clk", sel_clk, 2);
        repeat (3) cyc();
        chk("s1_init_wait_s_rst", s_rst, 1);
        wake_init();
        chk("s1_ramp_s_rst", s_rst, 0);
        chk("s1_ramp_sel_width0", sel_width, 0);
        pe_once(); chk("s1_step1", sel_width, 8'h10);
        pe_once(); chk("s1_step2", sel_width, 8'h20);
        pe_once(); chk("s1_step3", sel_width, 8'h30);
        pe_once(); chk("s1_step4", sel_width, 8'h40);
        chk("s1_done_early", done, 0);
        cyc();
        chk("s1_done", done, 1);
        chk("s1_at_target", at_target, 1);
        chk("s1_busy_off", busy, 0);
        cyc();
        chk("s1_done_once", done, 0);
        chk("s1_hold_width", sel_width, 8'h40);
        chk("s1_hold_sel_clk", sel_clk, 2);

        // Retarget from RUN downwards: 0x40 -> 0x10 -> 0x08
        start_req(8'h08, 8'h30, 4'd0, 3'd6);
        chk("s3_busy", busy, 1);
        chk("s3_at_target_off", at_target, 0);
        chk("s3_s_rst", s_rst, 0);
        pe_once(); chk("s3_step1", sel_width, 8'h10);
        chk("s3_s_rst_mid", s_rst, 0);
        pe_once(); chk("s3_step2", sel_width, 8'h08);
        cyc();
        chk("s3_done", done, 1);
        chk("s3_s_rst_end", s_rst, 0);
        chk("s3_sel_clk_kept", sel_clk, 2);
        cyc();
        chk("s3_done_once", done, 0);

        // Saturating ramp with hold_cyc=2: step on every 3rd period
        abort_req();
        chk("s2_abort_width", sel_width, 0);
        chk("s2_abort_s_rst", s_rst, 1);
        start_req(8'h25, 8'h10, 4'd2, 3'd2);
        wake_init();
        pe_once(); pe_once();
        chk("s2_hold_a", sel_width, 8'h00);
        pe_once(); chk("s2_step1", sel_width, 8'h10);
        pe_once(); pe_once();
        chk("s2_hold_b", sel_width, 8'h10);
        pe_once(); chk("s2_step2", sel_width, 8'h20);
        pe_once(); pe_once(); pe_once();
        chk("s2_step3_sat", sel_width, 8'h25);
        chk("s2_done_early", done, 0);
        cyc();
        chk("s2_done", done, 1);
        cyc();
        chk("s2_done_once", done, 0);
        chk("s2_at_target", at_target, 1);

        // Pause mid-ramp for 50 cycles with period events present
        abort_req();
        start_req(8'h40, 8'h10, 4'd1, 3'd2);
        wake_init();
        pe_once(); pe_once();
        chk("s4_pre_step", sel_width, 8'h10);
        pe_once();
        pause = 1'b1; pwm_cyc = 1'b1; pwm_clk_en = 1'b1;
        cyc();
        chk("s4_count_en_off", count_en, 0);
        repeat (49) cyc();
        chk("s4_frozen_width", sel_width, 8'h10);
        chk("s4_frozen_count_en", count_en, 0);
        chk("s4_frozen_busy", busy, 1);
        pause = 1'b0; pwm_cyc = 1'b0; pwm_clk_en = 1'b0;
        cyc();
        chk("s4_count_en_on", count_en, 1);
        chk("s4_resume_width", sel_width, 8'h10);
        pe_once(); chk("s4_resume_step", sel_width, 8'h20);

        // abort together with start during RAMP
        abort = 1'b1; start = 1'b1; target_width = 8'h10;
        cyc();
        abort = 1'b0; start = 1'b0;
        chk("s5_width", sel_width, 0);
        chk("s5_s_rst", s_rst, 1);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        cyc();
        chk("s5_stay_idle", busy, 0);
        chk("s5_no_done", done, 0);

        // Target already reached on entry to RAMP
        start_req(8'h00, 8'h10, 4'd0, 3'd3);
        chk("s6_sel_clk", sel_clk, 3);
        wake_init();
        chk("s6_no_done_yet", done, 0);
        cyc();
        chk("s6_done", done, 1);
        chk("s6_at_target", at_target, 1);

        // Asynchronous reset mid-ramp
        abort_req();
        start_req(8'h40, 8'h10, 4'd0, 3'd5);
        wake_init();
        pe_once(); chk("s7_pre_rst", sel_width, 8'h10);
        #1 rst = 1'b1;
        #1;
        chk("s7_rst_width", sel_width, 0);
        chk("s7_rst_s_rst", s_rst, 1);
        chk("s7_rst_sel_clk", sel_clk, 0);
        chk("s7_rst_busy", busy, 0);
        chk("s7_rst_count_en", count_en, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // step of zero behaves as one
        start_req(8'h03, 8'h00, 4'd0, 3'd1);
        wake_init();
        pe_once(); chk("s8_step1", sel_width, 1);
        pe_once(); chk("s8_step2", sel_width, 2);
        pe_once(); chk("s8_step3", sel_width, 3);
        cyc();
        chk("s8_done", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Soft-start / duty-ramp sequencer that drives one pwm instance's sel_width, sel_clk, count_en and s_rst. On a start request it resets the pwm counters, then steps the duty toward a target by a programmable step every N pwm periods, in either direction. It then holds the target until it is retargeted or aborted. It sits between the control register block and the pwm datapath.

Parameters:
B_WIDTH, 8, width of duty word; must match the pwm B_WIDTH.
B_CLK, 3, width of the clock-select word; must match the pwm B_CLK.
B_HOLD, 4, width of the periods-per-step counter.

Ports:
clk  in  1  system clock, the same clock as pwm.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request: latch target_width, step, hold_cyc and cfg_clk, then ramp.
abort  in  1  single-cycle request: stop and park the pwm inactive.
pause  in  1  level input; freezes the pwm and the ramp while high.
target_width  in  B_WIDTH  final duty word.
step  in  B_WIDTH  duty increment per step; 0 is treated as 1.
hold_cyc  in  B_HOLD  extra pwm periods between steps; 0 means step every period.
cfg_clk  in  B_CLK  pwm clock select.
pwm_cyc  in  1  pwm cyc output.
pwm_clk_en  in  1  pwm clk_en output.
sel_width  out  B_WIDTH  to pwm sel_width.
sel_clk  out  B_CLK  to pwm sel_clk.
count_en  out  1  to pwm count_en.
s_rst  out  1  to pwm s_rst.
busy  out  1  high in INIT and RAMP.
at_target  out  1  high in RUN.
done  out  1  one-cycle pulse when sel_width reaches the target.

Behaviour:
- Reset values: state IDLE, sel_width=0, sel_clk=0, count_en=1, s_rst=1, busy=0, at_target=0, done=0; all latched configuration registers = 0.
- Period event pe = pwm_cyc & pwm_clk_en & ~pause. All outputs are registered.
- count_en = ~pause in every state.
- IDLE:
  - s_rst=1, sel_width=0.
  - start -> INIT; latch target, step (0 becomes 1), hold_cyc and cfg_clk; sel_clk takes the latched cfg_clk on the next cycle.
- INIT:
  - s_rst=1.
  - On the first pwm_clk_en with pause=0 -> RAMP; s_rst=0 from the next cycle; hold counter cleared.
- RAMP:
  - s_rst=0.
  - On pe: if the hold counter == hold_cyc, clear it and apply one step to sel_width; otherwise increment it.
- Step rule (saturating, computed B_WIDTH+1 bits wide, never overshoots the target):
  - sel_width < target: sel_width = min(sel_width+step, target).
  - sel_width > target: sel_width = max(sel_width-step, target).
- RAMP exit: when the registered sel_width == target, done pulses for 1 cycle and the state moves to RUN in the same cycle. If sel_width already equals the target on entry to RAMP, done fires on the first RAMP cycle.
- RUN:
  - at_target=1; sel_width holds.
  - start -> RAMP from the current sel_width (retarget); INIT is not re-entered and s_rst stays 0.
- start in RAMP: retarget. Latch the new target, step and hold_cyc; clear the hold counter; keep the current sel_width. cfg_clk is latched only from IDLE.
- abort, any state -> IDLE next cycle: sel_width=0, s_rst=1, done suppressed.
- Priorities:
  - abort beats start in the same cycle.
  - start together with pause is accepted; progress waits for pause to drop.
- pause: freezes the hold counter and the INIT exit, and gates pe. State, sel_width and sel_clk hold.
- A new sel_width is visible to the pwm at its next cyc. The pwm buffers sel_width at cyc, so there is no mid-period glitch.
- Assertion of rst mid-ramp behaves exactly like power-on reset.

Decomposition:
- Shared package pwm_ctrl_pkg holds the state enum (IDLE, INIT, RAMP, RUN) and the step-saturation function.
- One sub-module, pwm_hold_timer: the B_HOLD-bit periods-per-step counter, with ports pe, clr, hold_cyc and tick.

Test Plan:
- rst released, no stimulus -> sel_width=0, s_rst=1, count_en=1, busy=0 held indefinitely.
- start with target=0x40, step=0x10, hold_cyc=0, cfg_clk=2 -> INIT until the first pwm_clk_en; then sel_width=0x10,0x20,0x30,0x40 on 4 consecutive pe; done pulses once; at_target=1; sel_clk=2.
- start with target=0x25, step=0x10, hold_cyc=2 -> steps every 3rd pe: 0x10, 0x20, 0x25 (saturates, no overshoot); done fires once.
- In RUN at 0x40, start with target=0x08, step=0x30 -> sel_width 0x10 then 0x08; s_rst stays 0 throughout.
- Mid-ramp pause held 50 cycles -> count_en=0, sel_width frozen, no pe counted; the ramp resumes exactly after pause drops.
- abort and start in the same cycle during RAMP -> IDLE, sel_width=0, s_rst=1, no done; a mid-ramp rst gives the same values asynchronously.
